io_uart_tx: RTL and testbench

- Serial UART transmitter that drains a valid/ready byte stream, normally the data_o/valid_o side of a peripheral TX FIFO, and drives one asynchronous serial line.
- Frame format, bit period and enable are runtime-configurable.
- Config is latched per frame, so register writes never corrupt a frame already in flight.
- Sits between the APB-side TX FIFO and the pad.

---
 rtl/io_uart_tx.sv | 143 ++++++++++++++
 tb/tb_io_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// UART transmitter: takes bytes from a valid/ready stream and serialises them onto tx_o.
// The frame format is captured at the handshake, so config writes only affect the next frame.
module io_uart_tx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_odd_i,
    input  logic                 cfg_stop2_i,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [1:0]           bits_q, bits_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_d, busy_d;
    logic                 bit_end, last_stop, last_data, hs;

    // bit_q counts data bits in DATA and stop bits in STOP.
    assign bit_end   = (cnt_q == div_q);
    assign last_stop = !stop2_q || (bit_q == 3'd1);
    assign last_data = (bit_q == ({1'b0, bits_q} + 3'd4));

    // Ready on the final stop cycle lets the next start bit follow with no idle gap.
    // Handshake rule: a byte moves on a rising clk edge where valid_i && ready_o.
    assign ready_o = cfg_en_i && !rst &&
                     (state_q == IDLE || (state_q == STOP && last_stop && bit_end));
    assign hs      = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bits_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bits_q    <= bits_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            tx_o      <= tx_d;
            busy_o    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || bit_end) ? '0 : cnt_q + DIV_WIDTH'(1);
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        case (state_q)
            IDLE: ;
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    parity_d = parity_q ^ shift_q[0];
                    if (last_data) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP;
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (hs) begin
            state_d   = START;
            cnt_d     = '0;
            bit_d     = '0;
            shift_d   = data_i;
            parity_d  = 1'b0;
            div_d     = cfg_div_i;
            bits_d    = cfg_bits_i;
            par_en_d  = cfg_parity_en_i;
            par_odd_d = cfg_parity_odd_i;
            stop2_d   = cfg_stop2_i;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d ^ par_odd_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a line-level model (queue of expected tx_o values, one per clk)
// checked every cycle, plus literal waveform checks for the directed scenarios.
module tb_io_uart_tx;

    localparam int DIV_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_en_i;
    logic [DIV_WIDTH-1:0] cfg_div_i;
    logic [1:0]           cfg_bits_i;
    logic                 cfg_parity_en_i;
    logic                 cfg_parity_odd_i;
    logic                 cfg_stop2_i;
    logic [7:0]           data_i;
    logic                 valid_i;
    logic                 ready_o;
    logic                 tx_o;
    logic                 busy_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    logic exp_q[$];

    io_uart_tx #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
        .cfg_bits_i(cfg_bits_i), .cfg_parity_en_i(cfg_parity_en_i),
        .cfg_parity_odd_i(cfg_parity_odd_i), .cfg_stop2_i(cfg_stop2_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .tx_o(tx_o), .busy_o(busy_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // model: whole frame is expanded into line samples at the handshake
    function automatic logic model_ready();
        return cfg_en_i && !rst && (exp_q.size() <= 1);
    endfunction

    task automatic push_frame();
        logic       line[$];
        logic       par;
        int         nb;
        int         per;
        logic [7:0] d;
        d   = data_i;
        nb  = int'(cfg_bits_i) + 5;
        per = int'(cfg_div_i) + 1;
        par = 1'b0;
        line.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            line.push_back(d[i]);
            par ^= d[i];
        end
        if (cfg_parity_en_i) line.push_back(par ^ cfg_parity_odd_i);
        line.push_back(1'b1);
        if (cfg_stop2_i) line.push_back(1'b1);
        foreach (line[i])
            for (int c = 0; c < per; c++) exp_q.push_back(line[i]);
    endtask

    always @(posedge clk) begin
        logic hs;
        if (rst) begin
            exp_q.delete();
        end else begin
            hs = valid_i && model_ready();
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (hs) push_frame();
        end
    end

    // scoreboard compare, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_o", 64'(tx_o), 64'((exp_q.size() != 0) ? exp_q[0] : 1'b1));
            check("busy_o", 64'(busy_o), 64'(exp_q.size() != 0));
            check("ready_o", 64'(ready_o), 64'(model_ready()));
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int div, input int bits, input logic pen, input logic podd,
                           input logic s2);
        cfg_div_i        = DIV_WIDTH'(div);
        cfg_bits_i       = 2'(bits);
        cfg_parity_en_i  = pen;
        cfg_parity_odd_i = podd;
        cfg_stop2_i      = s2;
    endtask

    task automatic wait_hs(output int n);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n++;
            if (valid_i && ready_o) begin
                next_cycle();
                return;
            end
        end
        check("handshake_timeout", 64'(0), 64'(1));
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        data_i  = d;
        valid_i = 1'b1;
        wait_hs(n);
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (!busy_o) begin
                next_cycle();
                return;
            end
        end
        check("idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic capture(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v[i] = tx_o;
        end
    endtask

    // bit i of t is the i-th line bit in time; each lasts per cycles
    function automatic logic [63:0] expand(input logic [15:0] t, input int nb, input int per);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb * per; i++) v[i] = t[i / per];
        return v;
    endfunction

    initial begin
        logic [63:0] v;
        int          n;
        rst = 1'b1;
        cfg_en_i = 1'b1;
        set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
        data_i  = 8'h00;
        valid_i = 1'b0;

        // reset
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_tx", 64'(tx_o), 64'(1));
        check("reset_busy", 64'(busy_o), 64'(0));
        check("reset_ready", 64'(ready_o), 64'(0));
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // 1: div=3 8N1 0x55
        send(8'h55);
        check("t1_model_len", 64'(exp_q.size()), 64'(40));
        capture(40, v);
        check("t1_line", v, expand(16'b1010101010, 10, 4));
        check("t1_ready_c40", 64'(ready_o), 64'(1));
        @(negedge clk);
        check("t1_idle_c41", 64'(busy_o), 64'(0));
        next_cycle();

        // 2: div=0, 7 bits, even then odd parity, 0x03
        set_cfg(0, 2, 1'b1, 1'b0, 1'b0);
        send(8'h03);
        capture(10, v);
        check("t2_even_line", v, expand(16'b1000000110, 10, 1));
        wait_idle();
        cfg_parity_odd_i = 1'b1;
        send(8'h03);
        capture(10, v);
        check("t2_odd_line", v, expand(16'b1100000110, 10, 1));
        wait_idle();

        // 3: div=1, 5 bits, 2 stop, 0xFF
        set_cfg(1, 0, 1'b0, 1'b0, 1'b1);
        send(8'hFF);
        capture(16, v);
        check("t3_line", v, 64'hFFFC);
        @(negedge clk);
        check("t3_len", 64'(busy_o), 64'(0));
        next_cycle();

        // 4: back-to-back at div=2 8N1
        set_cfg(2, 3, 1'b0, 1'b0, 1'b0);
        data_i  = 8'hA5;
        valid_i = 1'b1;
        wait_hs(n);
        data_i = 8'h3C;
        wait_hs(n);
        valid_i = 1'b0;
        check("t4_hs_spacing", 64'(n), 64'(30));
        capture(30, v);
        check("t4_second_line", v, expand(16'b1001111000, 10, 3));
        wait_idle();

        // 5: reset during DATA bit 3, then 0x81
        set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
        send(8'hF0);
        repeat (17) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("t5_ready_in_rst", 64'(ready_o), 64'(0));
        @(negedge clk);
        check("t5_rst_tx", 64'(tx_o), 64'(1));
        check("t5_rst_busy", 64'(busy_o), 64'(0));
        check("t5_rst_ready", 64'(ready_o), 64'(0));
        next_cycle();
        rst = 1'b0;
        next_cycle();
        send(8'h81);
        capture(40, v);
        check("t5_line", v, expand(16'b1100000010, 10, 4));
        wait_idle();

        // 6: enable gating and config isolation
        set_cfg(1, 3, 1'b0, 1'b0, 1'b0);
        cfg_en_i = 1'b0;
        data_i   = 8'h0F;
        valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_disabled_ready", 64'(ready_o), 64'(0));
            check("t6_disabled_tx", 64'(tx_o), 64'(1));
        end
        next_cycle();
        cfg_en_i = 1'b1;
        wait_hs(n);
        repeat (4) next_cycle();
        cfg_en_i        = 1'b0;
        cfg_parity_en_i = 1'b1;
        // 20-cycle 8N1 frame at div=1; 4 cycles already elapsed
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_o) break;
            n++;
        end
        check("t6_remaining_len", 64'(n), 64'(16));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_accept", 64'(busy_o), 64'(0));
        end
        next_cycle();
        valid_i = 1'b0;
        repeat (2) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
